pipe_ctrl: RTL and testbench

- Central pipeline sequencer for the five-stage core.
- Combines stall requests from ID, EX and MEM into the per-stage stall vector that freezes the pc, if_id, id_ex, ex_mem and mem_wb registers.
- Runs a small FSM that turns exception and eret requests into a timed flush pulse with a redirect PC.
- Has a stall watchdog that flags a pipeline frozen for too long.

---
 rtl/pipe_ctrl_if.sv | 33 +++
 rtl/pipe_ctrl.sv | 161 ++++++++++++++++
 tb/tb_pipe_ctrl.sv | 230 +++++++++++++++++++++++
 3 files changed

// File: rtl/pipe_ctrl_if.sv
// Pipeline control bus for pipe_ctrl: stall requests and exception/eret
// events coming up from the stages, and stall, flush and redirect outputs
// going back down to them. The master side is the datapath and the slave
// side is the sequencer.
interface pipe_ctrl_if;
  logic        stallreq_id;
  logic        stallreq_ex;
  logic        stallreq_mem;
  logic        excp_req;
  logic [31:0] excp_vec;
  logic        eret_req;
  logic [31:0] epc;
  logic [5:0]  stall;
  logic        flush;
  logic [31:0] new_pc;
  logic        stall_timeout;
  logic [31:0] perf_stall_cycles;
  logic [31:0] perf_flushes;

  modport master (
    output stallreq_id, stallreq_ex, stallreq_mem,
    output excp_req, excp_vec, eret_req, epc,
    input  stall, flush, new_pc, stall_timeout,
    input  perf_stall_cycles, perf_flushes
  );

  modport slave (
    input  stallreq_id, stallreq_ex, stallreq_mem,
    input  excp_req, excp_vec, eret_req, epc,
    output stall, flush, new_pc, stall_timeout,
    output perf_stall_cycles, perf_flushes
  );
endinterface

// File: rtl/pipe_ctrl.sv
// pipe_ctrl: central sequencer for the five-stage core.
// - Merges ID/EX/MEM stall requests into a per-register hold vector
//   (bit0 pc, bit1 if_id, bit2 id_ex, bit3 ex_mem, bit4 mem_wb, bit5 wb).
// - RUN/FLUSH FSM turns an exception or eret into a flush pulse that lasts
//   FLUSH_CYCLES cycles, together with the redirect PC.
// - Watchdog raises a sticky stall_timeout once the pipe has been held for
//   STALL_LIMIT consecutive cycles.
// Optional feature macro: PIPE_PERF_EN builds the stall-cycle and flush
// performance counters; without it both perf outputs are tied to zero.
module pipe_ctrl #(
  parameter int FLUSH_CYCLES = 1,
  parameter int STALL_LIMIT  = 255
) (
  input  logic        clk,
  input  logic        rst,
  pipe_ctrl_if.slave  bus
);

  typedef enum logic {
    RUN   = 1'b0,
    FLUSH = 1'b1
  } state_t;

  localparam logic [3:0]  FLUSH_INIT = 4'(FLUSH_CYCLES - 1);
  localparam logic [15:0] WD_LIMIT   = 16'(STALL_LIMIT);

  state_t      state;
  state_t      state_nxt;
  logic [3:0]  fcnt;
  logic [3:0]  fcnt_nxt;
  logic        flush_q;
  logic        flush_nxt;
  logic [31:0] new_pc_q;
  logic [31:0] new_pc_nxt;
  logic        accept_c;
  logic        event_c;
  logic [5:0]  stall_c;
  logic        stalled_c;
  logic [15:0] wd_cnt;
  logic [15:0] wd_inc;
  logic        timeout_q;

  // Watchdog increment that sticks at all-ones instead of wrapping.
  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  // Deepest requesting stage wins: a hold at stage k also holds every
  // register upstream of it so nothing gets overwritten.
  function automatic logic [5:0] stall_mask(input logic id,
                                            input logic ex,
                                            input logic mem);
    logic [5:0] m;
    m = 6'b000000;
    if (mem)     m = 6'b011111;
    else if (ex) m = 6'b001111;
    else if (id) m = 6'b000111;
    return m;
  endfunction

  assign event_c   = bus.excp_req | bus.eret_req;
  assign stalled_c = |stall_c;
  assign wd_inc    = sat_inc16(wd_cnt);

  // Same-cycle stall vector; forced low during reset and while flushing,
  // since a flush discards whatever the stages were waiting on.
  always_comb begin
    stall_c = 6'b000000;
    if (!rst && state == RUN)
      stall_c = stall_mask(bus.stallreq_id, bus.stallreq_ex, bus.stallreq_mem);
  end

  // Next-state logic: accept one event in RUN, then count out the flush.
  always_comb begin
    state_nxt  = state;
    flush_nxt  = flush_q;
    fcnt_nxt   = fcnt;
    new_pc_nxt = new_pc_q;
    accept_c   = 1'b0;
    case (state)
      RUN: begin
        if (event_c) begin
          state_nxt  = FLUSH;
          flush_nxt  = 1'b1;
          fcnt_nxt   = FLUSH_INIT;
          // Exception outranks eret when both commit together.
          new_pc_nxt = bus.excp_req ? bus.excp_vec : bus.epc;
          accept_c   = 1'b1;
        end
      end
      FLUSH: begin
        // Events arriving here are dropped; the redirect is already chosen.
        if (fcnt == 4'd0) begin
          state_nxt = RUN;
          flush_nxt = 1'b0;
        end else begin
          fcnt_nxt = fcnt - 4'd1;
        end
      end
    endcase
  end

  // FSM state, flush pulse and redirect target registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= RUN;
      flush_q  <= 1'b0;
      fcnt     <= 4'd0;
      new_pc_q <= 32'd0;
    end else begin
      state    <= state_nxt;
      flush_q  <= flush_nxt;
      fcnt     <= fcnt_nxt;
      new_pc_q <= new_pc_nxt;
    end
  end

  // Watchdog: count consecutive stalled edges; the flag latches until reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      wd_cnt    <= 16'd0;
      timeout_q <= 1'b0;
    end else if (stalled_c) begin
      wd_cnt <= wd_inc;
      if (wd_inc >= WD_LIMIT)
        timeout_q <= 1'b1;
    end else begin
      wd_cnt <= 16'd0;
    end
  end

  assign bus.stall         = stall_c;
  assign bus.flush         = flush_q;
  assign bus.new_pc        = new_pc_q;
  assign bus.stall_timeout = timeout_q;

`ifdef PIPE_PERF_EN
  logic [31:0] perf_stall_q;
  logic [31:0] perf_flush_q;

  // Free-running performance counters, wrapping modulo 2^32.
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_stall_q <= 32'd0;
      perf_flush_q <= 32'd0;
    end else begin
      if (stalled_c)
        perf_stall_q <= perf_stall_q + 32'd1;
      if (accept_c)
        perf_flush_q <= perf_flush_q + 32'd1;
    end
  end

  assign bus.perf_stall_cycles = perf_stall_q;
  assign bus.perf_flushes      = perf_flush_q;
`else
  assign bus.perf_stall_cycles = 32'd0;
  assign bus.perf_flushes      = 32'd0;
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// Testbench for pipe_ctrl. Two instances with different FLUSH_CYCLES /
// STALL_LIMIT share one stimulus stream; a cycle-level reference model
// predicts each instance's outputs into a queue and a monitor on the
// falling edge pops and compares.
module tb_pipe_ctrl;
  localparam int FC0 = 1;
  localparam int SL0 = 4;
  localparam int FC1 = 3;
  localparam int SL1 = 10;
  localparam int FCS [2] = '{FC0, FC1};
  localparam int SLS [2] = '{SL0, SL1};

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  pipe_ctrl_if bus0 ();
  pipe_ctrl_if bus1 ();

  pipe_ctrl #(.FLUSH_CYCLES(FC0), .STALL_LIMIT(SL0)) dut0 (
    .clk(clk), .rst(rst), .bus(bus0.slave));
  pipe_ctrl #(.FLUSH_CYCLES(FC1), .STALL_LIMIT(SL1)) dut1 (
    .clk(clk), .rst(rst), .bus(bus1.slave));

  typedef struct {
    bit          rst, id, ex, mem, excp, eret;
    logic [31:0] vec, epc;
  } stim_t;

  typedef struct packed {
    logic [5:0]  stall;
    logic        flush;
    logic [31:0] new_pc;
    logic        to;
    logic [31:0] psc;
    logic [31:0] pfl;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];
  int n_checks = 0;
  int n_pass   = 0;

  // Reference model state per instance.
  int          m_fl  [2];   // flush cycles still to be shown
  int          m_run [2];   // consecutive stalled edges
  bit          m_to  [2];
  logic [31:0] m_pc  [2];
  logic [31:0] m_psc [2];
  logic [31:0] m_pfl [2];

  function automatic stim_t idle();
    stim_t s;
    s.rst = 0; s.id = 0; s.ex = 0; s.mem = 0; s.excp = 0; s.eret = 0;
    s.vec = 32'd0; s.epc = 32'd0;
    return s;
  endfunction

  // Hold depth: a request at stage k holds registers 0..k.
  function automatic logic [5:0] ref_stall(int k, stim_t s);
    int depth;
    if (s.rst || m_fl[k] > 0) return 6'd0;
    depth = s.mem ? 5 : s.ex ? 4 : s.id ? 3 : 0;
    return 6'((1 << depth) - 1);
  endfunction

  function automatic exp_t ref_out(int k, stim_t s);
    exp_t e;
    e.stall  = ref_stall(k, s);
    e.flush  = (m_fl[k] > 0);
    e.new_pc = m_pc[k];
    e.to     = m_to[k];
`ifdef PIPE_PERF_EN
    e.psc = m_psc[k];
    e.pfl = m_pfl[k];
`else
    e.psc = 32'd0;
    e.pfl = 32'd0;
`endif
    return e;
  endfunction

  task automatic model_step(int k, stim_t s);
    logic [5:0] st;
    st = ref_stall(k, s);
    if (s.rst) begin
      m_fl[k] = 0; m_run[k] = 0; m_to[k] = 0;
      m_pc[k] = 32'd0; m_psc[k] = 32'd0; m_pfl[k] = 32'd0;
    end else begin
      if (m_fl[k] > 0) begin
        m_fl[k] = m_fl[k] - 1;
      end else if (s.excp || s.eret) begin
        m_fl[k]  = FCS[k];
        m_pc[k]  = s.excp ? s.vec : s.epc;
        m_pfl[k] = m_pfl[k] + 32'd1;
      end
      if (st != 6'd0) begin
        if (m_run[k] < 65535) m_run[k] = m_run[k] + 1;
        if (m_run[k] >= SLS[k]) m_to[k] = 1;
        m_psc[k] = m_psc[k] + 32'd1;
      end else begin
        m_run[k] = 0;
      end
    end
  endtask

  task automatic drive(stim_t s);
    rst = s.rst;
    bus0.stallreq_id = s.id;   bus1.stallreq_id = s.id;
    bus0.stallreq_ex = s.ex;   bus1.stallreq_ex = s.ex;
    bus0.stallreq_mem = s.mem; bus1.stallreq_mem = s.mem;
    bus0.excp_req = s.excp;    bus1.excp_req = s.excp;
    bus0.eret_req = s.eret;    bus1.eret_req = s.eret;
    bus0.excp_vec = s.vec;     bus1.excp_vec = s.vec;
    bus0.epc = s.epc;          bus1.epc = s.epc;
  endtask

  // One cycle: drive, predict this cycle's outputs, clock, advance model.
  task automatic apply(stim_t s);
    drive(s);
    q0.push_back(ref_out(0, s));
    q1.push_back(ref_out(1, s));
    @(posedge clk);
    model_step(0, s);
    model_step(1, s);
    #1;
  endtask

  task automatic chk(string nm, logic [31:0] act, logic [31:0] req);
    n_checks++;
    if (act !== req)
      $display("FAIL %s at %0t: actual=%h required=%h", nm, $time, act, req);
    else
      n_pass++;
  endtask

  // Monitor: compare every predicted cycle on the falling edge.
  always @(negedge clk) begin
    exp_t e;
    if (q0.size() > 0) begin
      e = q0.pop_front();
      chk("d0.stall", 32'(bus0.stall), 32'(e.stall));
      chk("d0.flush", 32'(bus0.flush), 32'(e.flush));
      chk("d0.new_pc", bus0.new_pc, e.new_pc);
      chk("d0.stall_timeout", 32'(bus0.stall_timeout), 32'(e.to));
      chk("d0.perf_stall_cycles", bus0.perf_stall_cycles, e.psc);
      chk("d0.perf_flushes", bus0.perf_flushes, e.pfl);
    end
    if (q1.size() > 0) begin
      e = q1.pop_front();
      chk("d1.stall", 32'(bus1.stall), 32'(e.stall));
      chk("d1.flush", 32'(bus1.flush), 32'(e.flush));
      chk("d1.new_pc", bus1.new_pc, e.new_pc);
      chk("d1.stall_timeout", 32'(bus1.stall_timeout), 32'(e.to));
      chk("d1.perf_stall_cycles", bus1.perf_stall_cycles, e.psc);
      chk("d1.perf_flushes", bus1.perf_flushes, e.pfl);
    end
  end

  initial begin
    stim_t s;
    s = idle();
    s.rst = 1;
    drive(s);
    @(posedge clk);
    model_step(0, s);
    model_step(1, s);
    #1;

    // Reset held with every request asserted.
    s = idle();
    s.rst = 1; s.id = 1; s.ex = 1; s.mem = 1; s.excp = 1; s.eret = 1;
    s.vec = 32'h20; s.epc = 32'h1000;
    repeat (2) apply(s);
    s = idle(); s.ex = 1;               apply(s);
    s = idle(); s.id = 1; s.mem = 1;    apply(s);
    s = idle(); s.id = 1;               apply(s);
    s = idle();                         apply(s);

    // Single exception.
    s = idle(); s.excp = 1; s.vec = 32'h20; apply(s);
    s = idle(); repeat (4) apply(s);

    // Exception + eret + mem stall together, then a late exception.
    s = idle(); s.excp = 1; s.vec = 32'h20; s.eret = 1; s.epc = 32'h1000;
    s.mem = 1; apply(s);
    s = idle(); s.mem = 1; apply(s);
    s = idle(); s.excp = 1; s.vec = 32'h40; apply(s);
    s = idle(); repeat (4) apply(s);

    // Watchdog bursts: 3 stalled cycles, gap, 4 stalled cycles, gap.
    s = idle(); s.id = 1; repeat (3) apply(s);
    s = idle(); apply(s);
    s = idle(); s.id = 1; repeat (4) apply(s);
    s = idle(); repeat (3) apply(s);
    s = idle(); s.ex = 1; repeat (12) apply(s);
    s = idle(); apply(s);

    // Reset during the second flush cycle.
    s = idle(); s.eret = 1; s.epc = 32'h1234; apply(s);
    s = idle(); apply(s);
    s = idle(); s.rst = 1; apply(s);
    s = idle(); repeat (3) apply(s);

    // Randomized traffic.
    for (int i = 0; i < 1500; i++) begin
      s.rst  = ($urandom_range(0, 59) == 0);
      s.id   = ($urandom_range(0, 99) < 30);
      s.ex   = ($urandom_range(0, 99) < 20);
      s.mem  = ($urandom_range(0, 99) < 15);
      s.excp = ($urandom_range(0, 99) < 6);
      s.eret = ($urandom_range(0, 99) < 5);
      s.vec  = $urandom;
      s.epc  = $urandom;
      apply(s);
    end
    s = idle(); apply(s);

    // Every prediction must have been consumed by the monitor.
    for (int i = 0; i < 5 && (q0.size() > 0 || q1.size() > 0); i++)
      @(negedge clk);
    if (q0.size() > 0 || q1.size() > 0) begin
      n_checks++;
      $display("FAIL drain: pending=%0d required=0", q0.size() + q1.size());
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
